// File: rtl/slice_demux_if.sv
`default_nettype none
// ============================================================================
// Module  : slice_demux_if
// Pixel-group input stream and per-slice output bus of slice_demux.
// Rev     : 1.0
// ============================================================================
interface slice_demux_if #(
  parameter int MAX_NBR_SLICES = 2
);
  localparam int C_GW = 4 * 3 * 14;

  logic [C_GW-1:0]                pixs_in;
  logic [3:0]                     pixs_in_valid;
  logic                           pixs_in_sof;
  logic                           pixs_in_ready;
  logic [MAX_NBR_SLICES-1:0]      slice_almost_full;
  logic [MAX_NBR_SLICES*C_GW-1:0] pixs_out_p;
  logic [MAX_NBR_SLICES-1:0]      pixs_out_valid;
  logic [MAX_NBR_SLICES-1:0]      pixs_out_sof;
  logic [MAX_NBR_SLICES-1:0]      pixs_out_eoc;

  // Upstream source plus downstream slice encoders.
  modport master (
    output pixs_in, pixs_in_valid, pixs_in_sof, slice_almost_full,
    input  pixs_in_ready, pixs_out_p, pixs_out_valid, pixs_out_sof, pixs_out_eoc
  );

  modport slave (
    input  pixs_in, pixs_in_valid, pixs_in_sof, slice_almost_full,
    output pixs_in_ready, pixs_out_p, pixs_out_valid, pixs_out_sof, pixs_out_eoc
  );
endinterface
`default_nettype wire

// File: rtl/slice_demux.sv
`default_nettype none
// ============================================================================
// Module  : slice_demux
// Splits raster 4-pixel groups into per-slice chunks, padding the last block.
// Rev     : 1.0
// ============================================================================
module slice_demux #(
  parameter int MAX_NBR_SLICES   = 2,
  parameter int MAX_SLICE_WIDTH  = 2560,
  parameter int MAX_SLICE_HEIGHT = 2560
) (
  input  logic                                clk_core,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [9:0]                          slices_per_line,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
  input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
  input  logic [15:0]                         frame_height,
  input  logic [3:0]                          eoc_valid_pixs,
  slice_demux_if.slave                        bus,
  output logic                                frame_done,
  output logic                                mask_err
);
  localparam int C_LW    = 3 * 14;
  localparam int C_GW    = 4 * C_LW;
  localparam int C_SW_W  = $clog2(MAX_SLICE_WIDTH);
  localparam int C_SH_W  = $clog2(MAX_SLICE_HEIGHT);
  localparam int C_SEL_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [C_SEL_W-1:0]             sel_q, sel_d, cur_sel;
  logic [C_SW_W-1:0]              grp_q, grp_d, cur_grp;
  logic [C_SH_W-1:0]              sline_q, sline_d, cur_sline;
  logic [15:0]                    fline_q, fline_d, cur_fline;
  logic [MAX_NBR_SLICES*C_GW-1:0] out_p_q, out_p_d;
  logic [MAX_NBR_SLICES-1:0]      out_valid_q, out_valid_d;
  logic [MAX_NBR_SLICES-1:0]      out_sof_q, out_sof_d;
  logic [MAX_NBR_SLICES-1:0]      out_eoc_q, out_eoc_d;
  logic [C_LW-1:0]                last_pix_q, last_pix_d;
  logic                           mask_err_q, mask_err_d;
  logic                           fdone_arm_q, fdone_arm_d;
  logic                           frame_done_q, frame_done_d;

  logic [C_SW_W-1:0]    g_cnt, r_cnt;
  logic [3:0]           n_last, last_mask, exp_mask;
  logic [1:0]           hi;
  logic [3:0][C_LW-1:0] lanes, filled, emit_data;
  logic                 ready, in_fire, restart, take, emit, chunk_end;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    grp_d        = grp_q;
    sline_d      = sline_q;
    fline_d      = fline_q;
    out_p_d      = out_p_q;
    out_valid_d  = '0;
    out_sof_d    = '0;
    out_eoc_d    = '0;
    last_pix_d   = last_pix_q;
    mask_err_d   = mask_err_q;
    fdone_arm_d  = 1'b0;
    frame_done_d = fdone_arm_q;
    emit         = 1'b0;
    chunk_end    = 1'b0;
    emit_data    = '0;
    hi           = 2'd0;

    g_cnt     = slice_width >> 2;
    r_cnt     = (eoc_valid_pixs <= 4'd4) ? g_cnt - C_SW_W'(1) : g_cnt;
    n_last    = (eoc_valid_pixs <= 4'd4) ? eoc_valid_pixs : eoc_valid_pixs - 4'd4;
    last_mask = 4'hF >> (4'd4 - n_last);

    case (state_q)
      PASS:       ready = ~bus.slice_almost_full[sel_q];
      PAD:        ready = 1'b0;
      default:    ready = 1'b1;
    endcase
    in_fire = ready & (|bus.pixs_in_valid);
    restart = in_fire & bus.pixs_in_sof;
    take    = in_fire & (restart | (state_q == PASS));

    // A sof group always opens a fresh frame at slice 0, group 0.
    cur_sel   = restart ? '0 : sel_q;
    cur_grp   = restart ? '0 : grp_q;
    cur_sline = restart ? '0 : sline_q;
    cur_fline = restart ? '0 : fline_q;

    exp_mask = (cur_grp == r_cnt - C_SW_W'(1)) ? last_mask : 4'hF;
    for (int p = 0; p < 4; p++) begin
      if (exp_mask[p]) hi = 2'(p);
    end
    lanes = bus.pixs_in;
    for (int p = 0; p < 4; p++) begin
      filled[p] = exp_mask[p] ? lanes[p] : lanes[hi];
    end

    if (take) begin
      emit       = 1'b1;
      emit_data  = filled;
      last_pix_d = filled[3];
      if (bus.pixs_in_valid != exp_mask) mask_err_d = 1'b1;
      state_d = PASS;
      sel_d   = cur_sel;
      grp_d   = cur_grp + C_SW_W'(1);
      sline_d = cur_sline;
      fline_d = cur_fline;
      if (cur_grp == r_cnt - C_SW_W'(1)) begin
        if (r_cnt < g_cnt) state_d = PAD;
        else               chunk_end = 1'b1;
      end
    end else if ((state_q == PAD) && !bus.slice_almost_full[sel_q]) begin
      emit      = 1'b1;
      emit_data = {4{last_pix_q}};
      chunk_end = 1'b1;
    end

    if (emit) begin
      out_valid_d[cur_sel]           = 1'b1;
      out_sof_d[cur_sel]             = (cur_grp == '0) && (cur_sline == '0);
      out_eoc_d[cur_sel]             = (cur_grp == g_cnt - C_SW_W'(1));
      out_p_d[cur_sel*C_GW +: C_GW]  = emit_data;
    end

    if (chunk_end) begin
      grp_d   = '0;
      state_d = PASS;
      if (10'(cur_sel) == slices_per_line - 10'd1) begin
        sel_d   = '0;
        sline_d = (cur_sline == slice_height - C_SH_W'(1)) ? '0 : cur_sline + C_SH_W'(1);
        fline_d = (cur_fline == frame_height - 16'd1) ? '0 : cur_fline + 16'd1;
        if (cur_fline == frame_height - 16'd1) begin
          state_d     = DONE;
          fdone_arm_d = 1'b1;
        end
      end else begin
        sel_d = cur_sel + C_SEL_W'(1);
      end
    end

    if (flush) begin
      state_d      = IDLE;
      sel_d        = '0;
      grp_d        = '0;
      sline_d      = '0;
      fline_d      = '0;
      out_valid_d  = '0;
      out_sof_d    = '0;
      out_eoc_d    = '0;
      mask_err_d   = 1'b0;
      fdone_arm_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      grp_q        <= '0;
      sline_q      <= '0;
      fline_q      <= '0;
      out_p_q      <= '0;
      out_valid_q  <= '0;
      out_sof_q    <= '0;
      out_eoc_q    <= '0;
      last_pix_q   <= '0;
      mask_err_q   <= 1'b0;
      fdone_arm_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      grp_q        <= grp_d;
      sline_q      <= sline_d;
      fline_q      <= fline_d;
      out_p_q      <= out_p_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eoc_q    <= out_eoc_d;
      last_pix_q   <= last_pix_d;
      mask_err_q   <= mask_err_d;
      fdone_arm_q  <= fdone_arm_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pixs_in_ready  = ready;
  assign bus.pixs_out_p     = out_p_q;
  assign bus.pixs_out_valid = out_valid_q;
  assign bus.pixs_out_sof   = out_sof_q;
  assign bus.pixs_out_eoc   = out_eoc_q;
  assign frame_done         = frame_done_q;
  assign mask_err           = mask_err_q;
endmodule
`default_nettype wire

// File: tb/tb_slice_demux.sv
`default_nettype none
// ============================================================================
// Module  : tb_slice_demux
// Directed table-driven bench for slice_demux.
// Rev     : 1.0
// ============================================================================
module tb_slice_demux;
  localparam int N  = 2;
  localparam int GW = 168;

  logic        clk_core = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [9:0]  slices_per_line;
  logic [11:0] slice_width;
  logic [11:0] slice_height;
  logic [15:0] frame_height;
  logic [3:0]  eoc_valid_pixs;
  logic        frame_done;
  logic        mask_err;

  slice_demux_if #(.MAX_NBR_SLICES(N)) bus ();

  slice_demux #(
    .MAX_NBR_SLICES  (N),
    .MAX_SLICE_WIDTH (2560),
    .MAX_SLICE_HEIGHT(2560)
  ) dut (
    .clk_core       (clk_core),
    .rst_n          (rst_n),
    .flush          (flush),
    .slices_per_line(slices_per_line),
    .slice_width    (slice_width),
    .slice_height   (slice_height),
    .frame_height   (frame_height),
    .eoc_valid_pixs (eoc_valid_pixs),
    .bus            (bus.slave),
    .frame_done     (frame_done),
    .mask_err       (mask_err)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [3:0] vld;
    logic       sof;
    logic       fl;
    logic [1:0] af;
    int         tag;
    logic       e_rdy;
    logic [1:0] e_val;
    logic [1:0] e_sof;
    logic [1:0] e_eoc;
    int         e_tag;
    int         e_hi;
    logic       e_all;
    logic       e_fd;
    logic       e_merr;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Component c of lane p of group "tag" carries tag*64 + p*8 + c.
  function automatic logic [41:0] pix_lane(int tag, int p);
    logic [41:0] l;
    for (int c = 0; c < 3; c++) l[c*14 +: 14] = 14'(tag * 64 + p * 8 + c);
    return l;
  endfunction

  function automatic logic [GW-1:0] group(int tag);
    logic [GW-1:0] g;
    for (int p = 0; p < 4; p++) g[p*42 +: 42] = pix_lane(tag, p);
    return g;
  endfunction

  // Lanes above hi (or every lane when all is set) repeat lane hi.
  function automatic logic [GW-1:0] exp_group(int tag, int hi, logic all);
    logic [GW-1:0] g;
    for (int p = 0; p < 4; p++) g[p*42 +: 42] = pix_lane(tag, (all || p > hi) ? hi : p);
    return g;
  endfunction

  // Fields: vld sof flush af tag | rdy val sof eoc etag ehi all fd merr
  function automatic vec_t mk(logic [3:0] vld, logic sof, logic fl, logic [1:0] af, int tag,
                              logic rdy, logic [1:0] val, logic [1:0] osof, logic [1:0] eoc,
                              int etag, int ehi, logic all, logic fd, logic merr);
    vec_t v;
    v.vld = vld; v.sof = sof; v.fl = fl; v.af = af; v.tag = tag;
    v.e_rdy = rdy; v.e_val = val; v.e_sof = osof; v.e_eoc = eoc;
    v.e_tag = etag; v.e_hi = ehi; v.e_all = all; v.e_fd = fd; v.e_merr = merr;
    return v;
  endfunction

  task automatic chk(string name, logic [GW-1:0] act, logic [GW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg(int spl, int sw, int sh, int fh, int eoc);
    slices_per_line = 10'(spl);
    slice_width     = 12'(sw);
    slice_height    = 12'(sh);
    frame_height    = 16'(fh);
    eoc_valid_pixs  = 4'(eoc);
  endtask

  task automatic run_vecs(string tname);
    foreach (vq[i]) begin
      vec_t v;
      int   s;
      v = vq[i];
      bus.pixs_in_valid     = v.vld;
      bus.pixs_in_sof       = v.sof;
      bus.slice_almost_full = v.af;
      bus.pixs_in           = group(v.tag);
      flush                 = v.fl;
      @(negedge clk_core);
      chk($sformatf("%s[%0d] ready", tname, i), GW'(bus.pixs_in_ready), GW'(v.e_rdy));
      @(posedge clk_core);
      #1;
      chk($sformatf("%s[%0d] valid", tname, i), GW'(bus.pixs_out_valid), GW'(v.e_val));
      chk($sformatf("%s[%0d] sof", tname, i), GW'(bus.pixs_out_sof), GW'(v.e_sof));
      chk($sformatf("%s[%0d] eoc", tname, i), GW'(bus.pixs_out_eoc), GW'(v.e_eoc));
      chk($sformatf("%s[%0d] frame_done", tname, i), GW'(frame_done), GW'(v.e_fd));
      chk($sformatf("%s[%0d] mask_err", tname, i), GW'(mask_err), GW'(v.e_merr));
      if (v.e_val != 2'b00) begin
        s = v.e_val[1] ? 1 : 0;
        chk($sformatf("%s[%0d] data", tname, i), bus.pixs_out_p[s*GW +: GW],
            exp_group(v.e_tag, v.e_hi, v.e_all));
      end
    end
    vq.delete();
    bus.pixs_in_valid     = 4'h0;
    bus.pixs_in_sof       = 1'b0;
    bus.slice_almost_full = 2'b00;
    flush                 = 1'b0;
  endtask

  initial begin
    rst_n                 = 1'b0;
    flush                 = 1'b0;
    bus.pixs_in           = '0;
    bus.pixs_in_valid     = 4'h0;
    bus.pixs_in_sof       = 1'b0;
    bus.slice_almost_full = 2'b00;
    cfg(2, 16, 2, 2, 8);
    repeat (2) @(posedge clk_core);
    @(negedge clk_core);
    chk("reset pixs_out_p", bus.pixs_out_p[GW-1:0] | bus.pixs_out_p[2*GW-1:GW], '0);
    chk("reset valid", GW'(bus.pixs_out_valid), '0);
    chk("reset sof", GW'(bus.pixs_out_sof), '0);
    chk("reset eoc", GW'(bus.pixs_out_eoc), '0);
    chk("reset frame_done", GW'(frame_done), '0);
    chk("reset mask_err", GW'(mask_err), '0);
    chk("reset ready", GW'(bus.pixs_in_ready), GW'(1));
    rst_n = 1'b1;
    @(posedge clk_core);
    #1;

    // Two slices, two lines per frame, no padding.
    vq.push_back(mk(4'hF,1,0,2'b00, 0, 1,2'b01,2'b01,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 1, 1,2'b01,2'b00,2'b00, 1,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 2, 1,2'b01,2'b00,2'b00, 2,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 3, 1,2'b01,2'b00,2'b01, 3,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 4, 1,2'b10,2'b10,2'b00, 4,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 5, 1,2'b10,2'b00,2'b00, 5,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 6, 1,2'b10,2'b00,2'b00, 6,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 7, 1,2'b10,2'b00,2'b10, 7,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 8, 1,2'b01,2'b00,2'b00, 8,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00, 9, 1,2'b01,2'b00,2'b00, 9,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,10, 1,2'b01,2'b00,2'b00,10,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,11, 1,2'b01,2'b00,2'b01,11,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,12, 1,2'b10,2'b00,2'b00,12,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,13, 1,2'b10,2'b00,2'b00,13,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,14, 1,2'b10,2'b00,2'b00,14,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,15, 1,2'b10,2'b00,2'b10,15,3,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b00, 0, 1,2'b00,2'b00,2'b00, 0,3,0,1,0));
    vq.push_back(mk(4'h0,0,0,2'b00, 0, 1,2'b00,2'b00,2'b00, 0,3,0,0,0));
    run_vecs("frame");

    // eoc=3: last real group fills lane3 from lane2, then one pad group.
    cfg(1, 16, 1, 4, 3);
    vq.push_back(mk(4'hF,1,0,2'b00,20, 1,2'b01,2'b01,2'b00,20,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,21, 1,2'b01,2'b00,2'b00,21,3,0,0,0));
    vq.push_back(mk(4'h7,0,0,2'b00,22, 1,2'b01,2'b00,2'b00,22,2,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,23, 0,2'b01,2'b00,2'b01,22,2,1,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,23, 1,2'b01,2'b01,2'b00,23,3,0,0,0));
    run_vecs("eoc3");

    // width=8: eoc=1 gives one real group plus pad; eoc=8 gives two real groups.
    cfg(1, 8, 1, 4, 1);
    vq.push_back(mk(4'h1,1,0,2'b00,30, 1,2'b01,2'b01,2'b00,30,0,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b00, 0, 0,2'b01,2'b00,2'b01,30,0,1,0,0));
    run_vecs("w8e1");
    cfg(1, 8, 1, 4, 8);
    vq.push_back(mk(4'hF,0,0,2'b00,31, 1,2'b01,2'b01,2'b00,31,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,32, 1,2'b01,2'b00,2'b01,32,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,33, 1,2'b01,2'b01,2'b00,33,3,0,0,0));
    run_vecs("w8e8");

    // Backpressure on slice 1 while sel=1 in PASS.
    cfg(2, 8, 1, 4, 8);
    vq.push_back(mk(4'hF,1,0,2'b00,40, 1,2'b01,2'b01,2'b00,40,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,41, 1,2'b01,2'b00,2'b01,41,3,0,0,0));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(4'hF,0,0,2'b10,42, 0,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,42, 1,2'b10,2'b10,2'b00,42,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,43, 1,2'b10,2'b00,2'b10,43,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,44, 1,2'b01,2'b01,2'b00,44,3,0,0,0));
    run_vecs("bp_pass");

    // Backpressure on slice 1 while in PAD.
    cfg(2, 16, 1, 4, 4);
    vq.push_back(mk(4'hF,1,0,2'b00,50, 1,2'b01,2'b01,2'b00,50,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,51, 1,2'b01,2'b00,2'b00,51,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,52, 1,2'b01,2'b00,2'b00,52,3,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b00, 0, 0,2'b01,2'b00,2'b01,52,3,1,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,53, 1,2'b10,2'b10,2'b00,53,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,54, 1,2'b10,2'b00,2'b00,54,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,55, 1,2'b10,2'b00,2'b00,55,3,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b10, 0, 0,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b10, 0, 0,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b00, 0, 0,2'b10,2'b00,2'b10,55,3,1,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,56, 1,2'b01,2'b01,2'b00,56,3,0,0,0));
    run_vecs("bp_pad");

    // sof mid-chunk on slice 1, then an unexpected lane mask.
    cfg(2, 16, 1, 4, 8);
    vq.push_back(mk(4'hF,1,0,2'b00,60, 1,2'b01,2'b01,2'b00,60,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,61, 1,2'b01,2'b00,2'b00,61,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,62, 1,2'b01,2'b00,2'b00,62,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,63, 1,2'b01,2'b00,2'b01,63,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,64, 1,2'b10,2'b10,2'b00,64,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,65, 1,2'b10,2'b00,2'b00,65,3,0,0,0));
    vq.push_back(mk(4'hF,1,0,2'b00,66, 1,2'b01,2'b01,2'b00,66,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,67, 1,2'b01,2'b00,2'b00,67,3,0,0,0));
    vq.push_back(mk(4'h3,0,0,2'b00,68, 1,2'b01,2'b00,2'b00,68,3,0,0,1));
    run_vecs("sof_mid");

    // flush during PAD, flush beating a simultaneous sof, then a clean frame.
    cfg(1, 16, 1, 4, 3);
    vq.push_back(mk(4'hF,1,0,2'b00,70, 1,2'b01,2'b01,2'b00,70,3,0,0,1));
    vq.push_back(mk(4'hF,0,0,2'b00,71, 1,2'b01,2'b00,2'b00,71,3,0,0,1));
    vq.push_back(mk(4'h7,0,0,2'b00,72, 1,2'b01,2'b00,2'b00,72,2,0,0,1));
    vq.push_back(mk(4'h0,0,1,2'b00, 0, 0,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b00, 0, 1,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,73, 1,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'hF,1,1,2'b00,77, 1,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,78, 1,2'b00,2'b00,2'b00, 0,3,0,0,0));
    vq.push_back(mk(4'hF,1,0,2'b00,74, 1,2'b01,2'b01,2'b00,74,3,0,0,0));
    vq.push_back(mk(4'hF,0,0,2'b00,75, 1,2'b01,2'b00,2'b00,75,3,0,0,0));
    vq.push_back(mk(4'h7,0,0,2'b00,76, 1,2'b01,2'b00,2'b00,76,2,0,0,0));
    vq.push_back(mk(4'h0,0,0,2'b00, 0, 0,2'b01,2'b00,2'b01,76,2,1,0,0));
    run_vecs("flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
